// File: rtl/x25519_ladder_sequencer_if.sv
// Engine-side bus of the X25519 ladder sequencer.
//   master : the sequencer. Drives the request (iter_en, iter_b, iter_xzm,
//            iter_xzm1, iter_work_low) and receives the result (iter_valid,
//            iter_xzm_out, iter_xzm1_out).
//   slave  : the single-iteration Montgomery-ladder engine.
// Projective pairs are packed {Z[511:256], X[255:0]}.
interface x25519_ladder_sequencer_if;
  logic         iter_en;
  logic         iter_b;
  logic [511:0] iter_xzm;
  logic [511:0] iter_xzm1;
  logic [263:0] iter_work_low;
  logic         iter_valid;
  logic [511:0] iter_xzm_out;
  logic [511:0] iter_xzm1_out;

  modport master (
    output iter_en, iter_b, iter_xzm, iter_xzm1, iter_work_low,
    input  iter_valid, iter_xzm_out, iter_xzm1_out
  );

  modport slave (
    input  iter_en, iter_b, iter_xzm, iter_xzm1, iter_work_low,
    output iter_valid, iter_xzm_out, iter_xzm1_out
  );
endinterface

// File: rtl/x25519_ladder_sequencer.sv
// X25519 Montgomery-ladder sequencer.
// Builds the initial projective pair from u_in, then issues one engine request
// per scalar bit (254 down to 0), feeding each engine result back as the next
// input, and finally presents the projective (X, Z) result with a done pulse.
// After reset it waits DRAIN_CYCLES before accepting work, because the engine
// itself has no reset and may still be finishing an earlier iteration.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle request, honoured only while ready=1
//   scalar, u_in   scalar e (little-endian bits) and input u-coordinate
//   ready          idle, drained, able to accept start
//   busy           ladder in progress
//   done           one-cycle pulse; x_out/z_out valid (held until next done)
//   x_out, z_out   final projective X and Z
//   eng            engine bus (master side), see x25519_ladder_sequencer_if
//
// Build option: define X25519_LADDER_CLAMP_EN to apply the RFC 7748 clamp to
// the scalar on start; otherwise the scalar is used as given.
module x25519_ladder_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [255:0]               scalar,
  input  logic [255:0]               u_in,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic [255:0]               x_out,
  output logic [255:0]               z_out,
  x25519_ladder_sequencer_if.master  eng
);

  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_DRAIN = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [255:0]  e_q, e_d;
  logic [255:0]  u_q, u_d;
  logic [511:0]  xzm_q, xzm_d;
  logic [511:0]  xzm1_q, xzm1_d;
  logic [7:0]    bit_idx_q, bit_idx_d;
  logic [255:0]  x_out_q, x_out_d;
  logic [255:0]  z_out_q, z_out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_DRAIN;
      cnt_q     <= '0;
      e_q       <= '0;
      u_q       <= '0;
      xzm_q     <= '0;
      xzm1_q    <= '0;
      bit_idx_q <= '0;
      x_out_q   <= '0;
      z_out_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      e_q       <= e_d;
      u_q       <= u_d;
      xzm_q     <= xzm_d;
      xzm1_q    <= xzm1_d;
      bit_idx_q <= bit_idx_d;
      x_out_q   <= x_out_d;
      z_out_q   <= z_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    e_d       = e_q;
    u_d       = u_q;
    xzm_d     = xzm_q;
    xzm1_d    = xzm1_q;
    bit_idx_d = bit_idx_q;
    x_out_d   = x_out_q;
    z_out_d   = z_out_q;

    case (state_q)
      S_DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_IDLE: begin
        if (start) begin
          e_d = scalar;
`ifdef X25519_LADDER_CLAMP_EN
          e_d[2:0] = 3'b000;
          e_d[255] = 1'b0;
          e_d[254] = 1'b1;
`endif
          u_d       = u_in;
          xzm_d     = {256'd0, 256'd1};
          xzm1_d    = {256'd1, u_in};
          bit_idx_d = 8'd254;
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: state_d = S_WAIT;

      S_WAIT: begin
        if (eng.iter_valid) begin
          xzm_d  = eng.iter_xzm_out;
          xzm1_d = eng.iter_xzm1_out;
          if (bit_idx_q == 8'd0) begin
            // Result registers load on the way into DONE so that x_out/z_out
            // are already valid in the cycle done is high.
            x_out_d = eng.iter_xzm_out[255:0];
            z_out_d = eng.iter_xzm_out[511:256];
            state_d = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q - 8'd1;
            state_d   = S_ISSUE;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_DRAIN;
    endcase
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done  = (state_q == S_DONE);
  assign x_out = x_out_q;
  assign z_out = z_out_q;

  // Request data comes straight from registers, so it stays stable from the
  // ISSUE cycle until the engine answers.
  assign eng.iter_en       = (state_q == S_ISSUE);
  assign eng.iter_b        = e_q[bit_idx_q];
  assign eng.iter_xzm      = xzm_q;
  assign eng.iter_xzm1     = xzm1_q;
  assign eng.iter_work_low = {8'h00, u_q};

endmodule

// File: tb/tb_x25519_ladder_sequencer.sv
module tb_x25519_ladder_sequencer;

  localparam int unsigned DRAIN = 16;
  localparam int          L     = 5;

`ifdef X25519_LADDER_CLAMP_EN
  localparam int ONES_ALL1 = 252;
  localparam int ONES_ZERO = 1;
`else
  localparam int ONES_ALL1 = 255;
  localparam int ONES_ZERO = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] scalar = '0;
  logic [255:0] u_in = '0;
  logic         ready, busy, done;
  logic [255:0] x_out, z_out;

  x25519_ladder_sequencer_if eng_if ();

  x25519_ladder_sequencer #(.DRAIN_CYCLES(DRAIN)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .scalar (scalar),
    .u_in   (u_in),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .x_out  (x_out),
    .z_out  (z_out),
    .eng    (eng_if)
  );

  always #5 clk = ~clk;

  // Stub engine (no reset, like the real one): answers L+1 cycles after the
  // request cycle with xzm+1 / xzm1+2.
  logic         stub_valid = 1'b0;
  logic         stray_valid = 1'b0;
  logic [511:0] stub_xzm_out = {16{32'hdeadbeef}};
  logic [511:0] stub_xzm1_out = {16{32'hcafef00d}};
  logic [511:0] cap_xzm, cap_xzm1;
  int           pend = 0;

  assign eng_if.iter_valid    = stub_valid | stray_valid;
  assign eng_if.iter_xzm_out  = stub_xzm_out;
  assign eng_if.iter_xzm1_out = stub_xzm1_out;

  // Behavioural model of the sequencer's externally visible contract.
  int           n_pass = 0, n_total = 0;
  int           cyc = 0;
  int           m_drain = 0;
  bit           m_active = 0, m_issue_due = 0, m_done_due = 0, m_fresh = 1;
  bit           ready_seen = 0;
  int           m_n = 0, m_run = 0, m_dones = 0, m_start_cyc = 0;
  int           m_en_cnt = 0, m_ones = 0;
  logic [255:0] m_e = '0, m_u = '0, m_x = '0, m_z = '0;
  logic [511:0] m_xzm = '0, m_xzm1 = '0;
  int           timeouts = 0;
  bit           final_req = 0, final_ack = 0;

  function automatic logic [255:0] model_e(input logic [255:0] s);
    logic [255:0] e;
    e = s;
`ifdef X25519_LADDER_CLAMP_EN
    e[2:0] = 3'b000;
    e[255] = 1'b0;
    e[254] = 1'b1;
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    logic         exp_ready, exp_busy;
    logic [255:0] exp_x, exp_z;
    cyc++;
    if (!rst_n) begin
      chk("rst_ctl", {ready, busy, done, eng_if.iter_en, eng_if.iter_b}, '0);
      chk("rst_xz", {z_out, x_out}, '0);
      chk("rst_req", eng_if.iter_xzm | eng_if.iter_xzm1 | {248'd0, eng_if.iter_work_low}, '0);
      m_drain = 0; m_active = 0; m_issue_due = 0; m_done_due = 0;
      m_fresh = 1; ready_seen = 0; m_x = '0; m_z = '0; m_n = 0;
    end else begin
      exp_ready = (m_drain >= DRAIN) && !m_active;
      exp_busy  = m_active && !m_done_due;
      exp_x = m_done_due ? m_xzm[255:0]   : m_x;
      exp_z = m_done_due ? m_xzm[511:256] : m_z;
      chk("ctl{ready,busy,done,iter_en}", {ready, busy, done, eng_if.iter_en},
          {exp_ready, exp_busy, m_done_due, m_issue_due});
      chk("xz_out", {z_out, x_out}, {exp_z, exp_x});
      if (ready && !ready_seen) begin
        ready_seen = 1;
        chk("drain_len", m_drain, 16);
      end
      if (m_fresh) begin
        chk("fresh_xzm", eng_if.iter_xzm, '0);
        chk("fresh_xzm1", eng_if.iter_xzm1, '0);
        chk("fresh_wl_b", {eng_if.iter_work_low, eng_if.iter_b}, '0);
      end
      if (exp_busy) begin
        chk("req_b", eng_if.iter_b, m_e[254 - m_n]);
        chk("req_xzm", eng_if.iter_xzm, m_xzm);
        chk("req_xzm1", eng_if.iter_xzm1, m_xzm1);
        chk("req_wl", eng_if.iter_work_low, {8'h00, m_u});
      end
      if (m_issue_due && m_n == 0 && m_run == 1) begin
        chk("first_xzm", eng_if.iter_xzm, {256'd0, 256'd1});
        chk("first_xzm1", eng_if.iter_xzm1, {256'd1, 256'd9});
        chk("first_wl", eng_if.iter_work_low, {8'h00, 256'd9});
      end
      if (eng_if.iter_en) begin
        m_en_cnt++;
        if (eng_if.iter_b) m_ones++;
      end
      if (m_done_due) begin
        chk("final_x", x_out, 256'd256);
        chk("final_z", z_out, 256'd0);
        chk("en_count", m_en_cnt, 255);
        if (m_run == 1) begin
          chk("latency", cyc - m_start_cyc + 1, 255 * 7 + 2);
          chk("ones_all1", m_ones, ONES_ALL1);
        end
        if (m_run == 3) chk("ones_zero", m_ones, ONES_ZERO);
      end
      if (final_req && !final_ack) begin
        chk("wait_timeouts", timeouts, 0);
        chk("done_total", m_dones, 2);
        final_ack = 1;
      end

      // model update
      if (m_drain < 1000000) m_drain++;
      m_x = exp_x; m_z = exp_z;
      if (m_done_due) begin m_done_due = 0; m_active = 0; m_dones++; end
      m_issue_due = 0;
      if (exp_ready && start) begin
        m_active = 1; m_fresh = 0; m_issue_due = 1;
        m_e = model_e(scalar); m_u = u_in;
        m_xzm = {256'd0, 256'd1}; m_xzm1 = {256'd1, u_in};
        m_n = 0; m_run++; m_start_cyc = cyc; m_en_cnt = 0; m_ones = 0;
      end
    end

    // stub engine step
    stub_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        stub_valid    = 1'b1;
        stub_xzm_out  = cap_xzm + 512'd1;
        stub_xzm1_out = cap_xzm1 + 512'd2;
        if (m_active && rst_n) begin
          m_xzm  = m_xzm + 512'd1;
          m_xzm1 = m_xzm1 + 512'd2;
          if (m_n == 254) m_done_due = 1;
          else begin m_n++; m_issue_due = 1; end
        end
      end
    end
    if (eng_if.iter_en && rst_n) begin
      cap_xzm  = eng_if.iter_xzm;
      cap_xzm1 = eng_if.iter_xzm1;
      pend     = L + 1;
    end
  end

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_stray;
    @(posedge clk); #1 stray_valid = 1'b1;
    @(posedge clk); #1 stray_valid = 1'b0;
  endtask

  task automatic wait_ready;
    int i;
    for (i = 0; i < 200 && !ready; i++) @(negedge clk);
    if (!ready) timeouts++;
  endtask

  task automatic wait_dones(input int target);
    int i;
    for (i = 0; i < 5000 && m_dones < target; i++) @(negedge clk);
    if (m_dones < target) timeouts++;
  endtask

  task automatic wait_iter(input int n);
    int i;
    for (i = 0; i < 5000 && m_n < n; i++) @(negedge clk);
    if (m_n < n) timeouts++;
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    // stray engine strobe and start while draining
    repeat (3) @(posedge clk);
    pulse_stray();
    scalar = '1; u_in = 256'd9;
    pulse_start();
    wait_ready();
    // stray engine strobes while idle
    pulse_stray();
    repeat (2) @(posedge clk);
    pulse_stray();
    repeat (3) @(negedge clk);

    // run A: all-ones scalar, u=9, extra start at iteration 10
    scalar = '1; u_in = 256'd9;
    pulse_start();
    wait_iter(10);
    @(posedge clk); #1 scalar = '0; u_in = 256'd77; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_dones(1);
    repeat (4) @(negedge clk);

    // run B: aborted by reset at iteration 100
    scalar = {32{8'hA5}}; u_in = {8{32'h13572468}};
    pulse_start();
    wait_iter(100);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready();
    repeat (2) @(negedge clk);

    // run C: zero scalar
    scalar = '0; u_in = 256'd9;
    pulse_start();
    wait_dones(2);
    repeat (6) @(negedge clk);

    final_req = 1;
    repeat (2) @(negedge clk);
    if (!final_ack) $display("FAIL final_handshake: got 0 expected 1");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
